// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the VRAM arbiter.
// Holds the VRAM geometry, host queue depth, display slot numbers,
// the host request entry layout and the read-return pipeline stage indices.
package vram_arb_pkg;

    localparam int VRAM_AW  = 12;
    localparam int VRAM_DW  = 8;
    localparam int HQ_DEPTH = 4;
    localparam int HQ_PW    = 2;   // pointer width, wraps 3->0
    localparam int HQ_LW    = 3;   // occupancy width, 0..4

    localparam logic [2:0] DISP_CHAR_SLOT = 3'd2;
    localparam logic [2:0] DISP_ATTR_SLOT = 3'd6;

    // Host request entry as stored in the queue.
    typedef struct packed {
        logic               we;
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] data;
    } hreq_t;

    localparam int REQ_W = $bits(hreq_t);

    // Read-return flag pipeline: a read moves RD_NONE -> RD_WAIT -> RD_DONE.
    // RD_NONE is the absence of a flag; the other two index the flag vector.
    localparam int RD_WAIT = 0;
    localparam int RD_DONE = 1;

endpackage

// File: rtl/vram_arbiter_hostq_fifo.sv
// hostq_fifo: 4-entry host request queue.
// Ports:
//   clk, rst         - clock, async active-high reset (empties the queue)
//   push, push_data  - write an entry (ignored when full)
//   pop              - drop the head entry (ignored when empty)
//   head_data        - current head entry (valid when !empty)
//   full, empty      - registered-occupancy status
//   level            - occupancy 0..4
module hostq_fifo
    import vram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REQ_W-1:0] push_data,
    input  logic             pop,
    output logic [REQ_W-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [HQ_LW-1:0] level
);

    localparam logic [HQ_PW-1:0] PTR_ONE  = 1;
    localparam logic [HQ_LW-1:0] LVL_ONE  = 1;
    localparam logic [HQ_LW-1:0] LVL_FULL = HQ_LW'(HQ_DEPTH);

    logic [REQ_W-1:0] mem_q [HQ_DEPTH];
    logic [REQ_W-1:0] mem_d [HQ_DEPTH];
    logic [HQ_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [HQ_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [HQ_LW-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // Full refuses a push even if a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HQ_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between display readout and a host.
// Display slots (active and readoutCount 2 or 6) always read dispAddr;
// every other cycle is a host slot that issues the queued head request.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   active, readoutCount, dispAddr    - readout side slot timing and address
//   hostReq/We/Addr/WrData, hostReady - host request handshake
//   hostRdData, hostRdValid           - host read return (one-cycle pulse)
//   vramRdEn/WrEn/Addr/WrData         - VRAM command (combinational)
//   vramRdData                        - VRAM read data, one cycle after RdEn
//   qLevel                            - host queue occupancy
module vram_arbiter
    import vram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic [2:0]         readoutCount,
    input  logic [VRAM_AW-1:0] dispAddr,
    input  logic               hostReq,
    input  logic               hostWe,
    input  logic [VRAM_AW-1:0] hostAddr,
    input  logic [VRAM_DW-1:0] hostWrData,
    output logic               hostReady,
    output logic [VRAM_DW-1:0] hostRdData,
    output logic               hostRdValid,
    output logic               vramRdEn,
    output logic               vramWrEn,
    output logic [VRAM_AW-1:0] vramAddr,
    output logic [VRAM_DW-1:0] vramWrData,
    input  logic [VRAM_DW-1:0] vramRdData,
    output logic [2:0]         qLevel
);

    hreq_t            push_req;
    hreq_t            head;
    logic [REQ_W-1:0] head_bits;
    logic             q_full, q_empty;
    logic             disp_slot, push, pop;

    logic [RD_DONE:RD_WAIT] rd_pipe_q, rd_pipe_d;
    logic [VRAM_DW-1:0]     host_rd_data_q, host_rd_data_d;

    assign disp_slot = active & ((readoutCount == DISP_CHAR_SLOT) |
                                 (readoutCount == DISP_ATTR_SLOT));

    assign push_req  = '{we: hostWe, addr: hostAddr, data: hostWrData};
    assign hostReady = ~q_full;
    assign push      = hostReq & ~q_full;
    // No host access is issued while reset is held.
    assign pop       = ~disp_slot & ~q_empty & ~rst;
    assign head      = hreq_t'(head_bits);

    hostq_fifo u_hostq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head_data (head_bits),
        .full      (q_full),
        .empty     (q_empty),
        .level     (qLevel)
    );

    always_comb begin
        vramRdEn   = 1'b0;
        vramWrEn   = 1'b0;
        vramAddr   = '0;
        vramWrData = '0;
        if (disp_slot) begin
            vramRdEn = 1'b1;
            vramAddr = dispAddr;
        end else if (pop) begin
            vramAddr = head.addr;
            if (head.we) begin
                vramWrEn   = 1'b1;
                vramWrData = head.data;
            end else begin
                vramRdEn = 1'b1;
            end
        end
    end

    // Only host reads enter the return pipeline, so display returns never
    // touch hostRdData. RD_WAIT marks the cycle the VRAM data is on the bus.
    always_comb begin
        rd_pipe_d          = '0;
        rd_pipe_d[RD_WAIT] = pop & ~head.we;
        rd_pipe_d[RD_DONE] = rd_pipe_q[RD_WAIT];
        host_rd_data_d     = rd_pipe_q[RD_WAIT] ? vramRdData : host_rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe_q      <= '0;
            host_rd_data_q <= '0;
        end else begin
            rd_pipe_q      <= rd_pipe_d;
            host_rd_data_q <= host_rd_data_d;
        end
    end

    assign hostRdValid = rd_pipe_q[RD_DONE];
    assign hostRdData  = host_rd_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed steps plus a cycle model/scoreboard
// that checks VRAM commands, queue level and host read returns every cycle.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active = 1'b0;
    logic [2:0]  readoutCount = 3'd0;
    logic [11:0] dispAddr = 12'hE00;
    logic        hostReq = 1'b0;
    logic        hostWe = 1'b0;
    logic [11:0] hostAddr = 12'h0;
    logic [7:0]  hostWrData = 8'h0;
    logic        hostReady, hostRdValid, vramRdEn, vramWrEn;
    logic [7:0]  hostRdData, vramWrData;
    logic [7:0]  vramRdData = 8'h0;
    logic [11:0] vramAddr;
    logic [2:0]  qLevel;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk(clk), .rst(rst), .active(active), .readoutCount(readoutCount),
        .dispAddr(dispAddr), .hostReq(hostReq), .hostWe(hostWe),
        .hostAddr(hostAddr), .hostWrData(hostWrData), .hostReady(hostReady),
        .hostRdData(hostRdData), .hostRdValid(hostRdValid),
        .vramRdEn(vramRdEn), .vramWrEn(vramWrEn), .vramAddr(vramAddr),
        .vramWrData(vramWrData), .vramRdData(vramRdData), .qLevel(qLevel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_init(input logic [11:0] a);
        return a[7:0] ^ 8'h3C ^ {a[11:8], a[11:8]};
    endfunction

    // Synchronous VRAM
    logic [7:0] ram [4096];
    initial for (int i = 0; i < 4096; i++) ram[i] = ram_init(12'(i));
    always @(posedge clk) begin
        if (vramRdEn) vramRdData <= ram[vramAddr];
        if (vramWrEn) ram[vramAddr] <= vramWrData;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: request queue, issue-time due list, expected read data.
    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
    } mreq_t;
    mreq_t      mq[$];
    int         due_q[$];
    logic [7:0] exp_rd[$];
    logic [7:0] last_rd = 8'h0;
    int         cyc = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete(); due_q.delete(); exp_rd.delete();
        end else begin
            automatic bit    m_disp = active && (readoutCount == 3'd2 || readoutCount == 3'd6);
            automatic int    n = mq.size();
            automatic mreq_t h;
            if (!m_disp && n > 0) begin
                h = mq.pop_front();
                if (!h.we) due_q.push_back(cyc + 2);
            end
            if (hostReq && n < 4) begin
                mq.push_back('{hostWe, hostAddr, hostWrData});
                if (!hostWe) exp_rd.push_back(ram_init(hostAddr));
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        automatic bit         disp, e_rd, e_wr, e_valid;
        automatic logic [11:0] e_addr;
        automatic logic [7:0]  e_wd;
        if (rst) begin
            mq.delete(); due_q.delete(); exp_rd.delete(); last_rd = 8'h0;
        end
        disp = active && (readoutCount == 3'd2 || readoutCount == 3'd6);
        e_rd = 0; e_wr = 0; e_addr = 12'h0; e_wd = 8'h0;
        if (disp) begin
            e_rd = 1; e_addr = dispAddr;
        end else if (mq.size() > 0) begin
            e_rd = !mq[0].we; e_wr = mq[0].we; e_addr = mq[0].addr; e_wd = mq[0].data;
        end
        chk("m_rd_en", vramRdEn, e_rd);
        chk("m_wr_en", vramWrEn, e_wr);
        chk("m_addr", vramAddr, e_addr);
        if (e_wr || (!disp && mq.size() == 0)) chk("m_wdata", vramWrData, e_wd);
        chk("m_qlevel", qLevel, mq.size());
        chk("m_ready", hostReady, mq.size() < 4);
        e_valid = due_q.size() > 0 && due_q[0] == cyc;
        chk("m_rd_valid", hostRdValid, e_valid);
        if (e_valid) begin
            void'(due_q.pop_front());
            if (exp_rd.size() > 0) last_rd = exp_rd.pop_front();
        end
        chk("m_rd_data", hostRdData, last_rd);
    end

    task automatic tick(input bit adv);
        @(posedge clk); #1;
        hostReq = 1'b0;
        if (adv && active) readoutCount = readoutCount + 3'd1;
        dispAddr = 12'hE00 | {9'd0, readoutCount};
    endtask

    task automatic req(input bit we, input logic [11:0] a, input logic [7:0] d);
        hostReq = 1'b1; hostWe = we; hostAddr = a; hostWrData = d;
    endtask

    initial begin
        // Reset state
        tick(1);
        @(negedge clk);
        chk("rst_qlevel", qLevel, 0);
        chk("rst_ready", hostReady, 1);
        chk("rst_valid", hostRdValid, 0);
        chk("rst_rdata", hostRdData, 0);
        tick(1);
        rst = 1'b0;

        // Write with display idle: issues the next cycle
        req(1, 12'h123, 8'h5A);
        tick(1);
        @(negedge clk);
        chk("wr_en", vramWrEn, 1);
        chk("wr_addr", vramAddr, 12'h123);
        chk("wr_data", vramWrData, 8'h5A);
        tick(1);
        @(negedge clk);
        chk("wr_qlevel", qLevel, 0);

        // Read whose head meets display slot 2: deferred to slot 3
        active = 1'b1; readoutCount = 3'd1; dispAddr = 12'hE01;
        req(0, 12'h040, 8'h00);
        tick(1);
        @(negedge clk);
        chk("def_disp_rd", vramRdEn, 1);
        chk("def_disp_addr", vramAddr, 12'hE02);
        chk("def_qlevel", qLevel, 1);
        tick(1);
        @(negedge clk);
        chk("def_issue_addr", vramAddr, 12'h040);
        chk("def_issue_rd", vramRdEn, 1);
        tick(1);
        @(negedge clk);
        chk("def_no_valid", hostRdValid, 0);
        tick(1);
        @(negedge clk);
        chk("def_valid", hostRdValid, 1);
        chk("def_rdata", hostRdData, ram_init(12'h040));

        // Fill the queue while slot 2 is held, fifth request refused
        readoutCount = 3'd1; dispAddr = 12'hE01;
        req(0, 12'h010, 8'h00);
        tick(0);
        readoutCount = 3'd2; dispAddr = 12'hE02;
        req(1, 12'h200, 8'hC1);
        tick(0);
        req(0, 12'h011, 8'h00);
        tick(0);
        req(1, 12'h201, 8'hC2);
        tick(0);
        req(0, 12'h3FF, 8'h00);
        @(negedge clk);
        chk("full_ready", hostReady, 0);
        chk("full_qlevel", qLevel, 4);
        tick(1);
        @(negedge clk);
        chk("ord0_addr", vramAddr, 12'h010);
        chk("ord0_rd", vramRdEn, 1);
        tick(1);
        @(negedge clk);
        chk("ord1_addr", vramAddr, 12'h200);
        chk("ord1_wdata", vramWrData, 8'hC1);
        tick(1);
        @(negedge clk);
        chk("ord2_addr", vramAddr, 12'h011);
        tick(1);
        @(negedge clk);
        chk("slot6_addr", vramAddr, 12'hE06);
        chk("slot6_qlevel", qLevel, 1);
        tick(1);
        @(negedge clk);
        chk("ord3_addr", vramAddr, 12'h201);
        chk("ord3_wr", vramWrEn, 1);
        tick(1);
        @(negedge clk);
        chk("drain_qlevel", qLevel, 0);

        // Four back-to-back reads, display idle
        active = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) req(0, 12'(k), 8'h00);
            tick(1);
            @(negedge clk);
            if (k + 1 >= 3 && k + 1 <= 6) begin
                chk("b2b_valid", hostRdValid, 1);
                chk("b2b_rdata", hostRdData, ram_init(12'(k - 2)));
            end else begin
                chk("b2b_idle", hostRdValid, 0);
            end
        end

        // Reset one cycle after a read issues, with another entry queued
        active = 1'b1; readoutCount = 3'd0; dispAddr = 12'hE00;
        req(0, 12'h050, 8'h00);
        tick(1);
        req(0, 12'h051, 8'h00);
        @(negedge clk);
        chk("rst_rd_issue", vramAddr, 12'h050);
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_qlevel", qLevel, 0);
        chk("rst_mid_ready", hostReady, 1);
        chk("rst_mid_valid", hostRdValid, 0);
        tick(1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            @(negedge clk);
            chk("rst_no_valid", hostRdValid, 0);
        end

        chk("sb_drained", exp_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
